// File: rtl/vga_capture_rx.sv
`timescale 1ns/1ps
// VGA capture receiver: recovers pixel timing from hsync/vsync, captures the
// active area once locked, and reports a per-frame colour checksum.
module vga_capture_rx #(
  parameter int H_ACT        = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_W     = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_ACT        = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525
) (
  input  logic        clk50mhz,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  color,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_color,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic [7:0]  err_count
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] HLOCK  = 2'd1;
  localparam logic [1:0] VWAIT  = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  localparam logic [9:0] HA       = 10'(H_ACT);
  localparam logic [9:0] HS_START = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END   = 10'(H_SYNC_START + H_SYNC_W);
  localparam logic [9:0] HS_W     = 10'(H_SYNC_W);
  localparam logic [9:0] HT       = 10'(H_TOTAL);
  localparam logic [9:0] HT_M1    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA       = 10'(V_ACT);
  localparam logic [9:0] VS_START = 10'(V_SYNC_START);
  localparam logic [9:0] VT_M1    = 10'(V_TOTAL - 1);

  logic        hs_s1_q, hs_s1_d, hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic        vs_s1_q, vs_s1_d, vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [5:0]  col_s1_q, col_s1_d, col_q, col_d;
  logic        phase_q, phase_d;
  logic [9:0]  rx_h_q, rx_h_d, rx_v_q, rx_v_d;
  logic [9:0]  per_q, per_d, low_q, low_d, low_w_q, low_w_d;
  logic [1:0]  state_q, state_d;
  logic        frame_ok_q, frame_ok_d;
  logic [15:0] acc_q, acc_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0]  pix_color_q, pix_color_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_sum_q, frame_sum_d;
  logic [7:0]  err_q, err_d;

  logic       hfall, hrise, vfall, strobe, in_lock, h_last, h_tol;
  logic       viol, capture, first_px, fd_cond;
  logic [9:0] h_cur, v_cur;

  always_comb begin
    hs_s1_d   = hsync;
    hs_d      = hs_s1_q;
    hs_prev_d = hs_q;
    vs_s1_d   = vsync;
    vs_d      = vs_s1_q;
    vs_prev_d = vs_q;
    col_s1_d  = color;
    col_d     = col_s1_q;
  end

  assign hfall   = ~hs_q & hs_prev_q;
  assign hrise   = hs_q & ~hs_prev_q;
  assign vfall   = ~vs_q & vs_prev_q;
  // hfall re-phases the strobe: it strobes now and every second clk after
  assign strobe  = hfall | phase_q;
  assign in_lock = (state_q == LOCKED);

  // Sync edges define the position of the current pixel rather than the next
  assign h_cur  = hfall ? HS_START : rx_h_q;
  assign v_cur  = vfall ? VS_START : rx_v_q;
  assign h_last = (h_cur == HT_M1);
  assign h_tol  = (rx_h_q == HT_M1) || (rx_h_q == 10'd0) || (rx_h_q == 10'd1);

  always_comb begin
    phase_d = hfall ? 1'b0 : ~phase_q;
    rx_h_d  = rx_h_q;
    rx_v_d  = v_cur;
    if (strobe) begin
      rx_h_d = h_last ? 10'd0 : h_cur + 10'd1;
      if (h_last) rx_v_d = (v_cur == VT_M1) ? 10'd0 : v_cur + 10'd1;
    end
    per_d = per_q;
    if (hfall)                          per_d = 10'd1;
    else if (strobe && per_q != 10'h3ff) per_d = per_q + 10'd1;
    low_d = low_q;
    if (hfall)                                  low_d = 10'd1;
    else if (strobe && !hs_q && low_q != 10'h3ff) low_d = low_q + 10'd1;
    low_w_d = hrise ? low_q : low_w_q;
  end

  always_comb begin
    viol = 1'b0;
    if (in_lock) begin
      if (hfall && rx_h_q != HS_START)                   viol = 1'b1;
      if (hrise && rx_h_q != HS_END)                     viol = 1'b1;
      if (vfall && (rx_v_q != VS_START || !h_tol))       viol = 1'b1;
      if (strobe && !hfall && per_q > HT)                viol = 1'b1;
    end
  end

  assign capture  = in_lock && strobe && (h_cur < HA) && (v_cur < VA);
  assign first_px = (h_cur == 10'd0) && (v_cur == 10'd0);
  assign fd_cond  = in_lock && strobe && (h_cur == 10'd0) && (v_cur == VA) &&
                    frame_ok_q && !viol;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: if (hfall && low_w_q == HS_W) state_d = HLOCK;
      HLOCK:  if (hfall) state_d = (per_q == HT && low_w_q == HS_W) ? VWAIT : SEARCH;
      VWAIT: begin
        if (vfall)                    state_d = LOCKED;
        else if (hfall && per_q != HT) state_d = SEARCH;
      end
      LOCKED: if (viol) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // A frame only counts if it stayed locked from pixel (0,0) onwards
  always_comb begin
    frame_ok_d = frame_ok_q;
    acc_d      = acc_q;
    if (!in_lock || viol) begin
      frame_ok_d = 1'b0;
      acc_d      = 16'd0;
    end else if (capture) begin
      if (first_px) begin
        frame_ok_d = 1'b1;
        acc_d      = {10'd0, col_q};
      end else begin
        acc_d      = acc_q + {10'd0, col_q};
      end
    end
  end

  always_comb begin
    pix_valid_d  = capture;
    pix_x_d      = capture ? h_cur : pix_x_q;
    pix_y_d      = capture ? v_cur : pix_y_q;
    pix_color_d  = capture ? col_q : pix_color_q;
    frame_done_d = fd_cond;
    frame_sum_d  = fd_cond ? acc_q : frame_sum_q;
    err_d        = (viol && err_q != 8'hff) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      hs_s1_q      <= 1'b1;
      hs_q         <= 1'b1;
      hs_prev_q    <= 1'b1;
      vs_s1_q      <= 1'b1;
      vs_q         <= 1'b1;
      vs_prev_q    <= 1'b1;
      col_s1_q     <= 6'd0;
      col_q        <= 6'd0;
      phase_q      <= 1'b0;
      rx_h_q       <= 10'd0;
      rx_v_q       <= 10'd0;
      per_q        <= 10'd0;
      low_q        <= 10'd0;
      low_w_q      <= 10'd0;
      state_q      <= SEARCH;
      frame_ok_q   <= 1'b0;
      acc_q        <= 16'd0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 10'd0;
      pix_y_q      <= 10'd0;
      pix_color_q  <= 6'd0;
      frame_done_q <= 1'b0;
      frame_sum_q  <= 16'd0;
      err_q        <= 8'd0;
    end else begin
      hs_s1_q      <= hs_s1_d;
      hs_q         <= hs_d;
      hs_prev_q    <= hs_prev_d;
      vs_s1_q      <= vs_s1_d;
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      col_s1_q     <= col_s1_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      rx_h_q       <= rx_h_d;
      rx_v_q       <= rx_v_d;
      per_q        <= per_d;
      low_q        <= low_d;
      low_w_q      <= low_w_d;
      state_q      <= state_d;
      frame_ok_q   <= frame_ok_d;
      acc_q        <= acc_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
      frame_done_q <= frame_done_d;
      frame_sum_q  <= frame_sum_d;
      err_q        <= err_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;
  assign frame_done = frame_done_q;
  assign frame_sum  = frame_sum_q;
  assign locked     = in_lock;
  assign err_count  = err_q;

endmodule

// File: tb/tb_vga_capture_rx.sv
`timescale 1ns/1ps
// Directed bench for vga_capture_rx on a shrunken raster (6x4 active, 12x8 total)
// so that several whole frames and hundreds of relock cycles fit in a short run.
module tb_vga_capture_rx;
  localparam int H_ACT = 6;
  localparam int H_SS  = 7;
  localparam int H_SW  = 3;
  localparam int H_TOT = 12;
  localparam int V_ACT = 4;
  localparam int V_SS  = 5;
  localparam int V_SW  = 2;
  localparam int V_TOT = 8;

  logic        clk50mhz = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [5:0]  color = 6'd0;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_color;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic        locked;
  logic [7:0]  err_count;

  int n_chk = 0;
  int n_err = 0;
  int pv_cnt, fd_cnt, fd_wide, bad_grad, last_sum;
  int min_x, max_x, min_y, max_y;
  bit lock_seen, fd_prev, grad_mode;

  vga_capture_rx #(
    .H_ACT(H_ACT), .H_SYNC_START(H_SS), .H_SYNC_W(H_SW), .H_TOTAL(H_TOT),
    .V_ACT(V_ACT), .V_SYNC_START(V_SS), .V_TOTAL(V_TOT)
  ) dut (
    .clk50mhz(clk50mhz), .reset(reset), .hsync(hsync), .vsync(vsync),
    .color(color), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .frame_done(frame_done), .frame_sum(frame_sum),
    .locked(locked), .err_count(err_count)
  );

  always #10 clk50mhz = ~clk50mhz;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint outs();
    return longint'({pix_valid, pix_x, pix_y, pix_color, frame_done,
                     frame_sum, locked, err_count});
  endfunction

  task automatic clr();
    pv_cnt = 0; fd_cnt = 0; fd_wide = 0; bad_grad = 0; last_sum = -1;
    min_x = 1023; max_x = -1; min_y = 1023; max_y = -1;
    lock_seen = 1'b0;
  endtask

  initial forever begin
    @(negedge clk50mhz);
    if (pix_valid) begin
      pv_cnt++;
      if (grad_mode && pix_color != pix_x[5:0]) bad_grad++;
      if (int'(pix_x) < min_x) min_x = int'(pix_x);
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) < min_y) min_y = int'(pix_y);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
    end
    if (frame_done) begin
      fd_cnt++;
      last_sum = int'(frame_sum);
      if (fd_prev) fd_wide++;
    end
    fd_prev = frame_done;
    if (locked) lock_seen = 1'b1;
  end

  // One source pixel lasts two clk; inputs change on the falling edge
  task automatic send_pix(input int h, input int v, input int hs_w, input bit vs_low);
    hsync = !(h >= H_SS && h < H_SS + hs_w);
    vsync = !vs_low;
    if (h < H_ACT && v < V_ACT) color = grad_mode ? 6'(h) : 6'd12;
    else                        color = 6'd0;
    repeat (2) @(negedge clk50mhz);
  endtask

  task automatic send_line(input int v, input int hs_w, input bit vs_low);
    for (int h = 0; h < H_TOT; h++) send_pix(h, v, hs_w, vs_low);
  endtask

  task automatic send_frame(input int hs_w);
    for (int v = 0; v < V_TOT; v++) send_line(v, hs_w, (v >= V_SS && v < V_SS + V_SW));
  endtask

  task automatic do_reset(input int n, input string tag);
    reset = 1'b1;
    hsync = 1'($urandom);
    vsync = 1'($urandom);
    color = 6'($urandom);
    repeat (n) @(negedge clk50mhz);
    chk(tag, outs(), 64'd0);
    reset = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    color = 6'd0;
    repeat (2) @(negedge clk50mhz);
    clr();
  endtask

  initial begin
    clr();
    grad_mode = 1'b0;
    @(negedge clk50mhz);

    // Reset with random pins, then an ideal constant-colour stream
    do_reset(3, "reset_outs");
    for (int v = 0; v < V_SS; v++) send_line(v, H_SW, 1'b0);
    chk("lock_before_vfall", longint'(locked), 64'd0);
    send_line(V_SS, H_SW, 1'b1);
    chk("lock_after_vfall", longint'(locked), 64'd1);
    send_line(V_SS + 1, H_SW, 1'b1);
    send_line(V_SS + 2, H_SW, 1'b0);
    repeat (2) send_frame(H_SW);
    chk("ideal_fd_cnt", longint'(fd_cnt), 64'd2);
    chk("ideal_sum", longint'(last_sum), 64'd288);
    chk("ideal_pix_cnt", longint'(pv_cnt), 64'd48);
    chk("ideal_fd_width", longint'(fd_wide), 64'd0);
    chk("ideal_err", longint'(err_count), 64'd0);
    chk("ideal_locked", longint'(locked), 64'd1);

    // Hsync pulse one pixel short never locks
    do_reset(3, "reset_outs_narrow");
    repeat (2) send_frame(H_SW - 1);
    chk("narrow_lock_seen", longint'(lock_seen), 64'd0);
    chk("narrow_err", longint'(err_count), 64'd0);
    chk("narrow_pix_cnt", longint'(pv_cnt), 64'd0);

    // One hsync pulse dropped mid-frame while locked
    do_reset(3, "reset_outs_drop");
    repeat (2) send_frame(H_SW);
    clr();
    send_line(0, H_SW, 1'b0);
    send_line(1, H_SW, 1'b0);
    send_line(2, 0, 1'b0);
    chk("drop_locked", longint'(locked), 64'd0);
    chk("drop_err", longint'(err_count), 64'd1);
    for (int v = 3; v < V_TOT; v++) send_line(v, H_SW, (v >= V_SS && v < V_SS + V_SW));
    chk("drop_no_fd", longint'(fd_cnt), 64'd0);
    chk("drop_relock", longint'(locked), 64'd1);
    send_frame(H_SW);
    chk("relock_fd", longint'(fd_cnt), 64'd1);
    chk("relock_sum", longint'(last_sum), 64'd288);
    chk("drop_err_hold", longint'(err_count), 64'd1);

    // Gradient colour = column index
    do_reset(3, "reset_outs_grad");
    grad_mode = 1'b1;
    repeat (3) send_frame(H_SW);
    chk("grad_color_x", longint'(bad_grad), 64'd0);
    chk("grad_pix_cnt", longint'(pv_cnt), 64'd48);
    chk("grad_min_x", longint'(min_x), 64'd0);
    chk("grad_max_x", longint'(max_x), 64'(H_ACT - 1));
    chk("grad_min_y", longint'(min_y), 64'd0);
    chk("grad_max_y", longint'(max_y), 64'(V_ACT - 1));
    chk("grad_sum", longint'(last_sum), 64'd60);
    grad_mode = 1'b0;

    // Vsync toggling every line: lock on one vfall, violate on the next
    do_reset(3, "reset_outs_viol");
    for (int i = 0; i < 6; i++) send_line(V_ACT, H_SW, (i % 2 == 1));
    chk("viol_first", longint'(err_count), 64'd1);
    for (int i = 6; i < 1210; i++) send_line(V_ACT, H_SW, (i % 2 == 1));
    chk("viol_saturate", longint'(err_count), 64'd255);

    // Reset in the middle of a line while locked
    repeat (2) send_frame(H_SW);
    chk("pre_rst_locked", longint'(locked), 64'd1);
    for (int h = 0; h < 4; h++) send_pix(h, 0, H_SW, 1'b0);
    do_reset(1, "midline_rst_outs");
    send_frame(H_SW);
    chk("rst_relock", longint'(locked), 64'd1);
    send_frame(H_SW);
    chk("rst_relock_fd", longint'(fd_cnt), 64'd1);
    chk("rst_relock_sum", longint'(last_sum), 64'd288);
    chk("rst_relock_err", longint'(err_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
